// File: rtl/hw_int_ctrl.sv
// rtl/hw_int_ctrl.sv - edge/level interrupt latch, mask and fixed-priority nesting in front of CP0 HWInt
module hw_int_ctrl #(
    parameter int              NIRQ     = 6,
    parameter logic [NIRQ-1:0] DEF_MASK = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] IrqIn,
    input  logic            WE,
    input  logic [1:0]      Addr,
    input  logic [31:0]     WData,
    output logic [31:0]     RData,
    output logic [NIRQ-1:0] HWInt,
    input  logic            IntTaken,
    input  logic            EXLClr,
    output logic            Busy
);

    typedef enum logic {IDLE, SERVICE} state_t;

    localparam logic [NIRQ-1:0] ONE = 1;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] mask_q, edge_q, prev_q;
    logic [NIRQ-1:0] edge_pend_q, edge_pend_d;
    logic [NIRQ-1:0] in_svc_q, in_svc_d;
    logic [NIRQ-1:0] pend, higher, top_bit, ack, w1c;
    logic [31:0]     status;
    logic            wr_mask, wr_edge, wr_pend;
    logic            unused_wdata;

    assign unused_wdata = ^WData[31:NIRQ];

    assign wr_mask = WE && (Addr == 2'd0);
    assign wr_edge = WE && (Addr == 2'd1);
    assign wr_pend = WE && (Addr == 2'd2);
    assign w1c     = wr_pend ? WData[NIRQ-1:0] : '0;

    // Level lines bypass the latch so dropping the line withdraws the request at once.
    assign pend   = (edge_q & edge_pend_q) | (~edge_q & IrqIn);
    assign higher = ~((in_svc_q << 1) - ONE);
    assign HWInt  = (state_q == SERVICE) ? (pend & mask_q & higher) : (pend & mask_q);
    assign Busy   = (state_q == SERVICE);

    always_comb begin
        top_bit = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (HWInt[i]) top_bit = ONE << i;
        end
    end

    // A nested take replaces InSvc outright; there is no stack of preempted lines.
    always_comb begin
        state_d  = state_q;
        in_svc_d = in_svc_q;
        ack      = '0;
        if (state_q == IDLE) begin
            if (IntTaken && (|HWInt)) begin
                in_svc_d = top_bit;
                state_d  = SERVICE;
            end
        end else begin
            if (IntTaken && (|HWInt)) begin
                in_svc_d = top_bit;
            end else if (EXLClr) begin
                ack      = in_svc_q & edge_q;
                in_svc_d = '0;
                state_d  = IDLE;
            end
        end
    end

    always_comb begin
        edge_pend_d = (edge_pend_q & ~(w1c | ack)) | (IrqIn & ~prev_q & edge_q);
        if (wr_edge) edge_pend_d = edge_pend_d & WData[NIRQ-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_svc_q    <= '0;
            mask_q      <= DEF_MASK;
            edge_q      <= '0;
            edge_pend_q <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_svc_q    <= in_svc_d;
            edge_pend_q <= edge_pend_d;
            prev_q      <= IrqIn;
            if (wr_mask) mask_q <= WData[NIRQ-1:0];
            if (wr_edge) edge_q <= WData[NIRQ-1:0];
        end
    end

    always_comb begin
        status              = '0;
        status[NIRQ-1:0]    = in_svc_q;
        status[8]           = Busy;
        case (Addr)
            2'd0:    RData = 32'(mask_q);
            2'd1:    RData = 32'(edge_q);
            2'd2:    RData = 32'(edge_pend_q);
            default: RData = status;
        endcase
    end

endmodule

// File: tb/tb_hw_int_ctrl.sv
// tb/tb_hw_int_ctrl.sv - directed and randomized checks of hw_int_ctrl against a line-index reference model
module tb_hw_int_ctrl;

    localparam int        NIRQ     = 6;
    localparam logic [5:0] DEF_MASK = 6'b000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  IrqIn = '0;
    logic        WE = 1'b0;
    logic [1:0]  Addr = '0;
    logic [31:0] WData = '0;
    logic [31:0] RData;
    logic [5:0]  HWInt;
    logic        IntTaken = 1'b0;
    logic        EXLClr = 1'b0;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    logic [5:0] m_mask, m_edge, m_epend, m_prev;
    int         m_svc;

    hw_int_ctrl #(.NIRQ(NIRQ), .DEF_MASK(DEF_MASK)) dut (
        .clk(clk), .reset(reset), .IrqIn(IrqIn), .WE(WE), .Addr(Addr), .WData(WData),
        .RData(RData), .HWInt(HWInt), .IntTaken(IntTaken), .EXLClr(EXLClr), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mask = DEF_MASK; m_edge = '0; m_epend = '0; m_prev = '0; m_svc = -1;
    endtask

    // A line is offered when pending, unmasked and numbered above the line in service.
    function automatic logic [5:0] exp_hw();
        logic [5:0] r = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if ((m_edge[i] ? m_epend[i] : IrqIn[i]) && m_mask[i] && (i > m_svc)) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [31:0] s = '0;
        case (Addr)
            2'd0: return {26'b0, m_mask};
            2'd1: return {26'b0, m_edge};
            2'd2: return {26'b0, m_epend};
            default: begin
                if (m_svc >= 0) begin
                    s[m_svc] = 1'b1;
                    s[8] = 1'b1;
                end
                return s;
            end
        endcase
    endfunction

    task automatic model_step();
        logic [5:0] hw = exp_hw();
        logic [5:0] clr;
        int top = -1;
        for (int i = 0; i < NIRQ; i++) if (hw[i]) top = i;
        clr = (WE && Addr == 2'd2) ? WData[5:0] : 6'b0;
        if (IntTaken && top >= 0) begin
            m_svc = top;
        end else if (EXLClr && m_svc >= 0) begin
            if (m_edge[m_svc]) clr[m_svc] = 1'b1;
            m_svc = -1;
        end
        for (int i = 0; i < NIRQ; i++) begin
            m_epend[i] = (m_edge[i] && IrqIn[i] && !m_prev[i]) || (m_epend[i] && !clr[i]);
        end
        if (WE && Addr == 2'd1) begin
            m_epend = m_epend & WData[5:0];
            m_edge  = WData[5:0];
        end
        if (WE && Addr == 2'd0) m_mask = WData[5:0];
        m_prev = IrqIn;
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("hwint", {26'b0, HWInt}, {26'b0, exp_hw()});
        chk("busy", {31'b0, Busy}, {31'b0, (m_svc >= 0)});
        chk("rdata", RData, exp_rdata());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        WE = 1'b1; Addr = a; WData = d;
        cycle();
        WE = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(tag, RData, exp);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_hwint", {26'b0, HWInt}, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        read_chk("rst_mask", 2'd0, {26'b0, DEF_MASK});
        read_chk("rst_status", 2'd3, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // level path
        write_reg(2'd0, 32'h3F);
        IrqIn = 6'h04;
        #1 chk("t1_level_on", {26'b0, HWInt}, 32'h04);
        cycle();
        IrqIn = 6'h00;
        #1 chk("t1_level_off", {26'b0, HWInt}, 32'h00);
        cycle();

        // edge latch, W1C, set beats clear
        write_reg(2'd1, 32'h01);
        IrqIn = 6'h01; cycle();
        IrqIn = 6'h00;
        read_chk("t2_pend_set", 2'd2, 32'h01);
        cycle(); cycle();
        read_chk("t2_pend_hold", 2'd2, 32'h01);
        write_reg(2'd2, 32'h01);
        read_chk("t2_pend_w1c", 2'd2, 32'h00);
        IrqIn = 6'h01;
        write_reg(2'd2, 32'h01);
        IrqIn = 6'h00;
        read_chk("t2_set_beats_clr", 2'd2, 32'h01);
        write_reg(2'd2, 32'h01);

        // priority and nesting
        write_reg(2'd1, 32'h00);
        IrqIn = 6'h12; IntTaken = 1'b1; cycle(); IntTaken = 1'b0;
        read_chk("t3_insvc4", 2'd3, 32'h110);
        chk("t3_masked", {26'b0, HWInt}, 32'h00);
        IrqIn = 6'h32;
        #1 chk("t3_higher", {26'b0, HWInt}, 32'h20);
        IntTaken = 1'b1; cycle(); IntTaken = 1'b0;
        read_chk("t3_insvc5", 2'd3, 32'h120);
        IrqIn = 6'h00; EXLClr = 1'b1; cycle(); EXLClr = 1'b0;
        cycle();

        // auto-ack on eret
        write_reg(2'd1, 32'h08);
        IrqIn = 6'h08; cycle(); IrqIn = 6'h00;
        IntTaken = 1'b1; cycle(); IntTaken = 1'b0;
        cycle();
        EXLClr = 1'b1; cycle(); EXLClr = 1'b0;
        read_chk("t4_pend", 2'd2, 32'h00);
        chk("t4_busy", {31'b0, Busy}, 32'h0);
        read_chk("t4_status", 2'd3, 32'h000);

        // simultaneous EXLClr and IntTaken
        write_reg(2'd1, 32'h02);
        IrqIn = 6'h02; cycle(); IrqIn = 6'h00;
        IntTaken = 1'b1; cycle(); IntTaken = 1'b0;
        read_chk("t5_insvc1", 2'd3, 32'h102);
        IrqIn = 6'h20; IntTaken = 1'b1; EXLClr = 1'b1; cycle();
        IntTaken = 1'b0; EXLClr = 1'b0;
        read_chk("t5_insvc5", 2'd3, 32'h120);
        read_chk("t5_pend_kept", 2'd2, 32'h02);
        cycle();

        // asynchronous reset mid-service
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        model_reset();
        chk("t6_busy", {31'b0, Busy}, 32'h0);
        read_chk("t6_status", 2'd3, 32'h0);
        read_chk("t6_pend", 2'd2, 32'h0);
        read_chk("t6_edge", 2'd1, 32'h0);
        read_chk("t6_mask", 2'd0, {26'b0, DEF_MASK});
        IrqIn = 6'h00;
        @(posedge clk);
        #1 reset = 1'b1;
        write_reg(2'd0, 32'h3F);

        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NIRQ; i++) if ($urandom_range(0, 3) == 0) IrqIn[i] = ~IrqIn[i];
            WE       = ($urandom_range(0, 9) == 0);
            Addr     = 2'($urandom_range(0, 3));
            WData    = $urandom;
            IntTaken = ($urandom_range(0, 4) == 0);
            EXLClr   = ($urandom_range(0, 4) == 0);
            cycle();
        end
        WE = 1'b0; IntTaken = 1'b0; EXLClr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
